fetch_iqueue: RTL and testbench

Parametrised fetch front end with an instruction queue. It replaces the single-instruction fetch path between the L1 instruction cache and decode. The block owns the fetch PC and requests one aligned block of BLOCK_INSTS instructions per cycle from the icache. On a hit it splits the block into instructions and buffers them, tagged with their PC, in an IQ_DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake, and a redirect input flushes the queue and restarts fetch at an arbitrary 4-byte-aligned PC.

---
 rtl/fetch_iqueue.sv | 116 +++++++++++
 tb/tb_fetch_iqueue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_iqueue.sv
// Fetch front end: owns the fetch PC, requests aligned icache blocks and
// buffers the instructions of each hit block, tagged with their PCs, for decode.
module fetch_iqueue #(
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   ISA_SIZE    = 32,
  parameter int                   BLOCK_INSTS = 2,
  parameter int                   IQ_DEPTH    = 8,
  parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  output logic [ADDR_SIZE-1:0]             pc_o,
  input  logic [BLOCK_INSTS*ISA_SIZE-1:0]  instblock_i,
  input  logic                             hit_i,
  input  logic                             redirect_i,
  input  logic [ADDR_SIZE-1:0]             redirect_pc_i,
  output logic                             deq_valid_o,
  output logic [ISA_SIZE-1:0]              deq_inst_o,
  output logic [ADDR_SIZE-1:0]             deq_pc_o,
  input  logic                             deq_ready_i,
  output logic                             iq_full_o,
  output logic                             iq_empty_o,
  output logic [$clog2(IQ_DEPTH+1)-1:0]    iq_count_o
);

  localparam int BLK_LSB = $clog2(BLOCK_INSTS*4);
  localparam int PTR_W   = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CNT_W   = $clog2(IQ_DEPTH+1);
  localparam int STORE   = 1 << PTR_W;

  logic [ADDR_SIZE-1:0] r_fpc;
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W-1:0]     r_wptr;
  logic [CNT_W-1:0]     r_count;

  logic [ISA_SIZE-1:0]  r_inst [STORE];
  logic [ADDR_SIZE-1:0] r_pc   [STORE];

  logic [ADDR_SIZE-1:0] w_pc_blk;
  logic [ADDR_SIZE-1:0] w_pc_next;
  logic [ADDR_SIZE-1:0] w_redirect_pc;
  logic [CNT_W-1:0]     w_off;
  logic [CNT_W-1:0]     w_n;
  logic [CNT_W-1:0]     w_free;
  logic [CNT_W-1:0]     w_count_next;
  logic                 w_push;
  logic                 w_pop;

  logic                 w_slot_en  [BLOCK_INSTS];
  logic [PTR_W-1:0]     w_slot_idx [BLOCK_INSTS];
  logic [ADDR_SIZE-1:0] w_slot_pc  [BLOCK_INSTS];

  assign w_pc_blk      = r_fpc & ~ADDR_SIZE'(BLOCK_INSTS*4 - 1);
  assign w_pc_next     = w_pc_blk + ADDR_SIZE'(BLOCK_INSTS*4);
  assign w_redirect_pc = redirect_pc_i & ~ADDR_SIZE'(3);

  assign w_off  = CNT_W'(r_fpc[BLK_LSB-1:0] >> 2);
  assign w_n    = CNT_W'(BLOCK_INSTS) - w_off;
  // Free space is judged on the start-of-cycle count; a same-cycle pop is not credited.
  assign w_free = CNT_W'(IQ_DEPTH) - r_count;
  assign w_push = hit_i & ~redirect_i & (w_free >= w_n);
  assign w_pop  = deq_valid_o & deq_ready_i;

  assign w_count_next = r_count + (w_push ? w_n : '0) - (w_pop ? CNT_W'(1) : '0);

  // Slots below the entry offset belong to addresses before fpc and are skipped.
  always_comb begin
    for (int i = 0; i < BLOCK_INSTS; i++) begin
      w_slot_en[i]  = w_push && (CNT_W'(i) >= w_off);
      w_slot_idx[i] = r_wptr + PTR_W'(i) - PTR_W'(w_off);
      w_slot_pc[i]  = w_pc_blk + ADDR_SIZE'(4*i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fpc   <= RESET_PC;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (redirect_i) begin
      r_fpc   <= w_redirect_pc;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc  <= w_pc_next;
        r_wptr <= r_wptr + PTR_W'(w_n);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Queue storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BLOCK_INSTS; i++) begin
      if (w_slot_en[i]) begin
        r_inst[w_slot_idx[i]] <= instblock_i[i*ISA_SIZE +: ISA_SIZE];
        r_pc[w_slot_idx[i]]   <= w_slot_pc[i];
      end
    end
  end

  assign pc_o        = w_pc_blk;
  assign iq_empty_o  = (r_count == '0);
  assign iq_full_o   = (r_count == CNT_W'(IQ_DEPTH));
  assign iq_count_o  = r_count;
  assign deq_valid_o = ~iq_empty_o & ~redirect_i;
  assign deq_inst_o  = r_inst[r_rptr];
  assign deq_pc_o    = r_pc[r_rptr];

endmodule

// File: tb/tb_fetch_iqueue.sv
// Bench for fetch_iqueue (BLOCK_INSTS=2, IQ_DEPTH=4): directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_fetch_iqueue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [63:0] instblock;
  logic        hit;
  logic        redir;
  logic [31:0] rpc;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        ready;
  logic        full;
  logic        empty;
  logic [2:0]  cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc;
  logic [31:0] popped[$];
  int          maxc;

  fetch_iqueue #(
    .ADDR_SIZE(32), .ISA_SIZE(32), .BLOCK_INSTS(2), .IQ_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_o(pc_o), .instblock_i(instblock),
    .hit_i(hit), .redirect_i(redir), .redirect_pc_i(rpc),
    .deq_valid_o(deq_valid), .deq_inst_o(deq_inst), .deq_pc_o(deq_pc),
    .deq_ready_i(ready), .iq_full_o(full), .iq_empty_o(empty), .iq_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [63:0] b, input logic r,
                       input logic [31:0] rp, input logic rd);
    @(negedge clk);
    hit = h; instblock = b; redir = r; rpc = rp; ready = rd;
    #1;
  endtask

  // Compare DUT against the model, advance the model by one clock, then clock the DUT.
  task automatic step();
    logic        exp_v;
    logic [31:0] blk;
    int          off;
    int          sz;
    logic        do_pop;
    logic        do_push;
    exp_v = (q.size() > 0) && !redir;
    chk("count", 32'(cnt), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 4));
    chk("pc_o", pc_o, m_fpc & ~32'h7);
    chk("deq_valid", 32'(deq_valid), 32'(exp_v));
    if (exp_v) begin
      chk("deq_inst", deq_inst, q[0].inst);
      chk("deq_pc", deq_pc, q[0].pc);
      if (ready) popped.push_back(deq_pc);
    end
    if (redir) begin
      q.delete();
      m_fpc = rpc & ~32'h3;
    end else begin
      blk     = m_fpc & ~32'h7;
      off     = int'(m_fpc[2]);
      sz      = q.size();
      do_pop  = (sz > 0) && ready;
      do_push = hit && ((4 - sz) >= (2 - off));
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        for (int k = off; k < 2; k++)
          q.push_back('{(k == 0) ? instblock[31:0] : instblock[63:32], blk + 32'(4*k)});
        m_fpc = blk + 32'h8;
      end
    end
    @(posedge clk);
    #1;
    if (int'(cnt) > maxc) maxc = int'(cnt);
  endtask

  initial begin
    logic [63:0] blk_f;
    blk_f = {32'h00200113, 32'h00100093};
    hit = 0; instblock = '0; redir = 0; rpc = '0; ready = 0;
    rst_n = 0;
    q.delete(); m_fpc = 32'h0; maxc = 0;
    #12;
    chk("rst_count", 32'(cnt), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_valid", 32'(deq_valid), 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    @(negedge clk); rst_n = 1;

    // Fill with no drain
    drive(1, blk_f, 0, 0, 0); step();
    chk("fill1_count", 32'(cnt), 32'd2); chk("fill1_pc", pc_o, 32'h8);
    drive(1, blk_f, 0, 0, 0); step();
    chk("fill2_count", 32'(cnt), 32'd4); chk("fill2_full", 32'(full), 32'h1);
    chk("fill2_pc", pc_o, 32'h10);
    drive(1, blk_f, 0, 0, 0); step();
    chk("fill3_count", 32'(cnt), 32'd4); chk("fill3_pc", pc_o, 32'h10);
    chk("fill_head_valid", 32'(deq_valid), 32'h1);
    chk("fill_head_inst", deq_inst, 32'h00100093);
    chk("fill_head_pc", deq_pc, 32'h0);

    // Conservative space check
    drive(0, blk_f, 0, 0, 1); step();
    chk("cons_pre_count", 32'(cnt), 32'd3);
    drive(1, blk_f, 0, 0, 1); step();
    chk("cons_count", 32'(cnt), 32'd2); chk("cons_pc", pc_o, 32'h10);
    drive(1, blk_f, 0, 0, 0); step();
    chk("cons_next_count", 32'(cnt), 32'd4); chk("cons_next_pc", pc_o, 32'h18);

    // Misaligned redirect with 3 entries queued
    drive(0, blk_f, 0, 0, 1); step();
    drive(1, blk_f, 1, 32'h26, 1);
    chk("redir_valid", 32'(deq_valid), 32'h0);
    step();
    chk("redir_count", 32'(cnt), 32'd0); chk("redir_pc", pc_o, 32'h20);
    drive(1, {32'h0000006F, 32'hDEADBEEF}, 0, 0, 0); step();
    chk("redir_push_count", 32'(cnt), 32'd1); chk("redir_push_pc", pc_o, 32'h28);
    chk("redir_head_inst", deq_inst, 32'h0000006F);
    chk("redir_head_pc", deq_pc, 32'h24);

    // Miss stall
    for (int i = 0; i < 3; i++) begin
      drive(0, blk_f, 0, 0, 0); step();
      chk("miss_count", 32'(cnt), 32'd1); chk("miss_pc", pc_o, 32'h28);
    end

    // Reset mid-run with 3 entries
    drive(1, blk_f, 0, 0, 0); step();
    chk("prerst_count", 32'(cnt), 32'd3);
    @(negedge clk); hit = 0; ready = 0; #2 rst_n = 0; #1;
    chk("mrst_count", 32'(cnt), 32'h0); chk("mrst_empty", 32'(empty), 32'h1);
    chk("mrst_valid", 32'(deq_valid), 32'h0); chk("mrst_pc", pc_o, 32'h0);
    q.delete(); m_fpc = 32'h0;
    @(negedge clk); rst_n = 1;
    drive(1, blk_f, 0, 0, 0); step();
    chk("post_rst_count", 32'(cnt), 32'd2); chk("post_rst_pc0", deq_pc, 32'h0);
    drive(0, blk_f, 0, 0, 1); step();
    chk("post_rst_pc1", deq_pc, 32'h4);

    // Drain order across pointer wrap
    drive(0, blk_f, 1, 32'h0, 0); step();
    popped.delete(); maxc = 0;
    for (int i = 0; i < 40 && m_fpc < 32'h30; i++) begin
      drive(1, {m_fpc + 32'h4, m_fpc}, 0, 0, 1); step();
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      drive(0, blk_f, 0, 0, 1); step();
    end
    chk("drain_total", 32'(popped.size()), 32'd12);
    for (int i = 0; i < popped.size() && i < 12; i++)
      chk("drain_pc", popped[i], 32'(4*i));
    chk("drain_count_bound", 32'(maxc <= 4), 32'h1);

    // PC wraps modulo 2^32
    drive(0, blk_f, 1, 32'hFFFFFFFE, 0); step();
    chk("wrap_redir_pc", pc_o, 32'hFFFFFFF8);
    drive(1, blk_f, 0, 0, 0); step();
    chk("wrap_pc", pc_o, 32'h0); chk("wrap_head_pc", deq_pc, 32'hFFFFFFFC);
    chk("wrap_head_inst", deq_inst, 32'h00200113);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 19) == 0,
            $urandom, 1'($urandom_range(0, 1)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
